ddr_cmd_sequencer: RTL and testbench
====================================

Name: ddr_cmd_sequencer

Overview:
- Host-side command initiator for the DRAM bank timing model.
- Accepts single-burst read/write requests over a valid/ready handshake and emits the one-hot 19-bit command vector plus bg/ba/row that the bank TimingFSM consumes.
- Enforces tRCD, tRP, tRFC and burst/write-recovery spacing, closed-page policy, and periodic refresh.
- Exposes a state code using the same 5-bit encoding as BankFSM, so benches can compare the two sides directly.

Parameters:
- BGWIDTH, 2, bank-group address width (0 for DDR3).
- BAWIDTH, 2, bank address width.
- ROWWIDTH, 16, row address width.
- BL, 8, read burst occupancy in cycles.
- T_RCD, 17, ACT to RD/WR cycles.
- T_WR, 14, WR to PR cycles (write burst plus recovery).
- T_RP, 17, PR to next command cycles.
- T_RFC, 34, REF to next command cycles.
- T_REFI, 9360, refresh interval in cycles.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request this cycle.
- req_write  in  1  1=write, 0=read.
- req_bg  in  BGWIDTH  target bank group.
- req_ba  in  BAWIDTH  target bank.
- req_row  in  ROWWIDTH  target row.
- commands  out  19  one-hot {ACT,BST,CFG,CKEH,CKEL,DPD,DPDX,MRR,MRW,PD,PDX,PR,PRA,RD,RDA,REF,SRF,WR,WRA}. Bit 18=ACT, bit 0=WRA.
- bg  out  BGWIDTH  command bank group.
- ba  out  BAWIDTH  command bank.
- row  out  ROWWIDTH  command row, valid with ACT.
- seq_state  out  5  BankFSM-encoded state.
- ref_pending  out  1  refresh due and not yet issued.

Behaviour:
- Reset (asynchronous, reset_n low):
  - Outputs: commands=0, bg=0, ba=0, row=0, seq_state=5'h00, req_ready=0, ref_pending=0.
  - Refresh counter loads T_REFI-1.
  - req_ready may rise on the first clk edge after reset_n goes high.
- All outputs are registered. Each command is a single-cycle pulse; at most one commands bit is high per cycle.
- Handshake:
  - req_ready=1 only in IDLE with ref_pending=0.
  - A request is accepted on a rising edge with req_valid&&req_ready. req_write, bg, ba and row are captured on that edge.
  - req_ready drops the cycle after acceptance.
- Timing, with acceptance at edge 0:
  - ACT is driven at cycle 1.
  - RD/WR is driven at cycle 1+T_RCD.
- States and codes:
  - IDLE 5'h00.
  - ACTIVATING 5'h01: entered with ACT; T_RCD cycles.
  - READING 5'h0b: BL cycles.
  - WRITING 5'h12: T_WR cycles.
  - PRECHARGING 5'h0a: T_RP cycles, entered with PR.
  - REFRESHING 5'h0d: T_RFC cycles, entered with REF.
  - Transitions:
    - ACTIVATING -> READING/WRITING, issuing RD/WR.
    - READING/WRITING -> PRECHARGING, issuing PR at R+BL (read) or R+T_WR (write), where R is the RD/WR cycle.
    - PRECHARGING -> IDLE.
    - REFRESHING -> IDLE.
- The 5'h03 (active) code is never held, because the column command is issued at tRCD expiry.
- Duration counters:
  - Load N-1 on entry and leave the state on reaching 0.
  - Width is $clog2 of the maximum of the timing parameters.
  - A parameter value of 1 gives a single-cycle state.
- Refresh:
  - A free-running down-counter sets ref_pending on reaching 0 and reloads T_REFI-1.
  - Expiry while ref_pending is already set is absorbed; there is no debt counting.
  - REF is issued from IDLE on the cycle after ref_pending is seen, with bg=0, ba=0. ref_pending clears with REF.
- Simultaneous req_valid and ref_pending in IDLE: refresh wins, the request waits and req_ready stays 0.
- A refresh that falls due mid-access does not interrupt the sequence; it is serviced at the next IDLE.
- bg/ba/row hold their last values between commands.
- Reset mid-sequence returns immediately to the reset values. No PR is issued and any in-flight request is dropped.

Optional Feature:
- DDR_AUTO_PRECHARGE_EN defined:
  - RDA replaces RD and WRA replaces WR.
  - Burst states are READING_AP 5'h0c and WRITING_AP 5'h13.
  - At burst end the sequencer enters PRECHARGING with no PR pulse, so PR is never asserted.
  - Cycle timing is identical to the non-AP flow.
- Undefined: explicit RD/WR followed by a PR pulse, as described above.

Test Plan:
- Write, defaults, bg=1 ba=1 row=0x1234, accepted at cycle 0:
  - ACT plus row=0x1234 at cycle 1; WR at 18; PR at 32.
  - seq_state 01->12->0a->00; req_ready=1 again at cycle 49.
- Read, same target:
  - ACT at 1, RD at 18, seq_state=0b for cycles 18-25, PR at 26, req_ready at 43.
- DDR_AUTO_PRECHARGE_EN:
  - Write: WRA at 18, seq_state 13 for 14 cycles, then 0a with no PR bit, idle at 49.
  - Read: RDA at 18, seq_state 0c, then 0a at 26.
- T_REFI=100, no traffic:
  - ref_pending=1 at cycle 100; REF at 101 with bg=ba=0.
  - seq_state=0d for 34 cycles; req_ready returns at 135.
- Refresh due during a write (T_REFI=20, request at 0):
  - The write completes untouched.
  - REF issued on the cycle after PRECHARGING ends; a req_valid held high meanwhile is accepted only after REFRESHING.
- reset_n low at cycle 10 during ACTIVATING:
  - All outputs 0 asynchronously, no PR emitted.
  - After release, a new request is accepted and the ACT sequence restarts.

Source files
------------

// File: rtl/ddr_cmd_sequencer.sv
// Single-bank DDR command initiator: ACT -> RD/WR -> PR with closed-page policy and periodic REF.
// Define DDR_AUTO_PRECHARGE_EN to issue RDA/WRA and drop the explicit PR pulse.
module ddr_cmd_sequencer #(
    parameter int BGWIDTH  = 2,
    parameter int BAWIDTH  = 2,
    parameter int ROWWIDTH = 16,
    parameter int BL       = 8,
    parameter int T_RCD    = 17,
    parameter int T_WR     = 14,
    parameter int T_RP     = 17,
    parameter int T_RFC    = 34,
    parameter int T_REFI   = 9360
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [BGWIDTH-1:0]  req_bg,
    input  logic [BAWIDTH-1:0]  req_ba,
    input  logic [ROWWIDTH-1:0] req_row,
    output logic [18:0]         commands,
    output logic [BGWIDTH-1:0]  bg,
    output logic [BAWIDTH-1:0]  ba,
    output logic [ROWWIDTH-1:0] row,
    output logic [4:0]          seq_state,
    output logic                ref_pending
);

    localparam int TMAX_A = (BL > T_RCD) ? BL : T_RCD;
    localparam int TMAX_B = (T_WR > T_RP) ? T_WR : T_RP;
    localparam int TMAX_C = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
    localparam int TMAX   = (TMAX_C > T_RFC) ? TMAX_C : T_RFC;
    localparam int CW     = ($clog2(TMAX) < 1) ? 1 : $clog2(TMAX);
    localparam int RW     = ($clog2(T_REFI) < 1) ? 1 : $clog2(T_REFI);

    localparam int B_ACT = 18;
    localparam int B_PR  = 7;
    localparam int B_RD  = 5;
    localparam int B_RDA = 4;
    localparam int B_REF = 3;
    localparam int B_WR  = 1;
    localparam int B_WRA = 0;

    typedef enum logic [4:0] {
        S_IDLE       = 5'h00,
        S_ACTIVATING = 5'h01,
        S_READING    = 5'h0b,
        S_READING_AP = 5'h0c,
        S_WRITING    = 5'h12,
        S_WRITING_AP = 5'h13,
        S_PRECHARGE  = 5'h0a,
        S_REFRESHING = 5'h0d
    } state_t;

`ifdef DDR_AUTO_PRECHARGE_EN
    localparam state_t S_RBURST = S_READING_AP;
    localparam state_t S_WBURST = S_WRITING_AP;
    localparam int     B_COLRD  = B_RDA;
    localparam int     B_COLWR  = B_WRA;
    localparam bit     PR_PULSE = 1'b0;
`else
    localparam state_t S_RBURST = S_READING;
    localparam state_t S_WBURST = S_WRITING;
    localparam int     B_COLRD  = B_RD;
    localparam int     B_COLWR  = B_WR;
    localparam bit     PR_PULSE = 1'b1;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [RW-1:0]         refcnt_q, refcnt_d;
    logic                  ref_pending_q, ref_pending_d;
    logic                  req_ready_q, req_ready_d;
    logic                  write_q, write_d;
    logic [18:0]           commands_q, commands_d;
    logic [BGWIDTH-1:0]    bg_q, bg_d;
    logic [BAWIDTH-1:0]    ba_q, ba_d;
    logic [ROWWIDTH-1:0]   row_q, row_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        commands_d    = '0;
        bg_d          = bg_q;
        ba_d          = ba_q;
        row_d         = row_q;
        ref_pending_d = ref_pending_q;
        refcnt_d      = (refcnt_q == '0) ? RW'(T_REFI - 1) : refcnt_q - 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (ref_pending_q) begin
                    state_d              = S_REFRESHING;
                    cnt_d                = CW'(T_RFC - 1);
                    commands_d[B_REF]    = 1'b1;
                    bg_d                 = '0;
                    ba_d                 = '0;
                    ref_pending_d        = 1'b0;
                end else if (req_valid && req_ready_q) begin
                    state_d              = S_ACTIVATING;
                    cnt_d                = CW'(T_RCD - 1);
                    commands_d[B_ACT]    = 1'b1;
                    write_d              = req_write;
                    bg_d                 = req_bg;
                    ba_d                 = req_ba;
                    row_d                = req_row;
                end
            end
            S_ACTIVATING: begin
                // Column command goes out at tRCD expiry, so the open-row code is never held.
                if (cnt_q == '0) begin
                    if (write_q) begin
                        state_d             = S_WBURST;
                        cnt_d               = CW'(T_WR - 1);
                        commands_d[B_COLWR] = 1'b1;
                    end else begin
                        state_d             = S_RBURST;
                        cnt_d               = CW'(BL - 1);
                        commands_d[B_COLRD] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RBURST, S_WBURST: begin
                if (cnt_q == '0) begin
                    state_d          = S_PRECHARGE;
                    cnt_d            = CW'(T_RP - 1);
                    commands_d[B_PR] = PR_PULSE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PRECHARGE, S_REFRESHING: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // An expiry on the same edge as REF re-arms the request rather than being lost.
        if (refcnt_q == '0) ref_pending_d = 1'b1;

        req_ready_d = (state_d == S_IDLE) && !ref_pending_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            refcnt_q      <= RW'(T_REFI - 1);
            ref_pending_q <= 1'b0;
            req_ready_q   <= 1'b0;
            write_q       <= 1'b0;
            commands_q    <= '0;
            bg_q          <= '0;
            ba_q          <= '0;
            row_q         <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            refcnt_q      <= refcnt_d;
            ref_pending_q <= ref_pending_d;
            req_ready_q   <= req_ready_d;
            write_q       <= write_d;
            commands_q    <= commands_d;
            bg_q          <= bg_d;
            ba_q          <= ba_d;
            row_q         <= row_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign ref_pending = ref_pending_q;
    assign commands    = commands_q;
    assign bg          = bg_q;
    assign ba          = ba_q;
    assign row         = row_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Bench for ddr_cmd_sequencer: timeline-based reference model, fixed scenarios plus random traffic.
// Honours DDR_AUTO_PRECHARGE_EN the same way as the design.
module tb_ddr_cmd_sequencer;

    localparam int TREFI = 100;
    localparam int BL = 8, T_RCD = 17, T_WR = 14, T_RP = 17, T_RFC = 34;
`ifdef DDR_AUTO_PRECHARGE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    logic        clk, reset_n, req_valid, req_ready, req_write, ref_pending;
    logic [1:0]  req_bg, req_ba, bg, ba;
    logic [15:0] req_row, row;
    logic [18:0] commands;
    logic [4:0]  seq_state;
    logic [45:0] dut_bus;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one operation timeline (start edge, end edge) plus refresh bookkeeping.
    int          t, t0, op_end;
    bit          op_ref, m_write, m_pend, m_ready;
    logic [1:0]  m_bg, m_ba;
    logic [15:0] m_row;

    ddr_cmd_sequencer #(
        .BGWIDTH(2), .BAWIDTH(2), .ROWWIDTH(16), .BL(BL), .T_RCD(T_RCD),
        .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(TREFI)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
        .commands(commands), .bg(bg), .ba(ba), .row(row),
        .seq_state(seq_state), .ref_pending(ref_pending)
    );

    assign dut_bus = {commands, bg, ba, row, seq_state, req_ready, ref_pending};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        t = 0; t0 = 0; op_end = 0; op_ref = 0; m_write = 0;
        m_pend = 0; m_ready = 0; m_bg = '0; m_ba = '0; m_row = '0;
    endtask

    function automatic logic [45:0] expected();
        logic [18:0] c = '0;
        logic [4:0]  s = 5'h00;
        int o = t - t0;
        int d = m_write ? T_WR : BL;
        if (t < op_end) begin
            if (op_ref) begin
                s = 5'h0d;
                if (o == 0) c[3] = 1'b1;
            end else if (o < T_RCD) begin
                s = 5'h01;
                if (o == 0) c[18] = 1'b1;
            end else if (o < T_RCD + d) begin
                s = m_write ? (AP ? 5'h13 : 5'h12) : (AP ? 5'h0c : 5'h0b);
                if (o == T_RCD) c[m_write ? (AP ? 0 : 1) : (AP ? 4 : 5)] = 1'b1;
            end else begin
                s = 5'h0a;
                if (o == T_RCD + d && !AP) c[7] = 1'b1;
            end
        end
        return {c, m_bg, m_ba, m_row, s, m_ready, m_pend};
    endfunction

    // Advance one clock edge; model sees the same inputs the DUT sampled. Returns at the negedge.
    task automatic tick();
        bit idle_pre, start_ref, start_acc;
        @(posedge clk);
        t++;
        idle_pre  = (t - 1 >= op_end);
        start_ref = idle_pre && m_pend;
        start_acc = idle_pre && !m_pend && m_ready && req_valid;
        if (start_ref) begin
            op_ref = 1; t0 = t; op_end = t + T_RFC; m_bg = '0; m_ba = '0;
        end else if (start_acc) begin
            op_ref = 0; t0 = t; m_write = req_write;
            op_end = t + T_RCD + (req_write ? T_WR : BL) + T_RP;
            m_bg = req_bg; m_ba = req_ba; m_row = req_row;
        end
        m_pend  = (m_pend && !start_ref) || (t % TREFI == 0);
        m_ready = (t >= op_end) && !m_pend;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        #1;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (dut_bus !== 46'h0) begin
            n_err++; $display("FAIL reset_state got=%h exp=%h", dut_bus, 46'h0);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        n_cmp++;
        if (dut_bus !== expected() || req_ready !== 1'b1) begin
            n_err++; $display("FAIL ready_after_reset got=%h exp=%h", dut_bus, expected());
        end
    endtask

    task automatic test_access(input bit wr);
        int acc, col_t = -1, pre_t = -1, rdy_t = -1, pr_cnt = 0;
        int d = wr ? T_WR : BL;
        logic [4:0] burst_code = wr ? (AP ? 5'h13 : 5'h12) : (AP ? 5'h0c : 5'h0b);
        logic [4:0] col_state = 5'h1f;
        apply_reset();
        tick();
        req_valid = 1; req_write = wr; req_bg = 2'd1; req_ba = 2'd1; req_row = 16'h1234;
        tick();
        acc = t; req_valid = 0;
        n_cmp++;
        if (commands !== 19'h40000 || row !== 16'h1234 || seq_state !== 5'h01 || bg !== 2'd1 || ba !== 2'd1) begin
            n_err++; $display("FAIL act_issue wr=%0d got cmd=%h row=%h st=%h exp cmd=40000 row=1234 st=01", wr, commands, row, seq_state);
        end
        for (int i = 0; i < 60; i++) begin
            tick();
            n_cmp++;
            if (dut_bus !== expected()) begin
                n_err++; $display("FAIL access_cycle wr=%0d t=%0d got=%h exp=%h", wr, t, dut_bus, expected());
            end
            if ((commands & 19'h00033) != 0 && col_t < 0) begin col_t = t - acc; col_state = seq_state; end
            if (seq_state == 5'h0a && pre_t < 0) pre_t = t - acc;
            if (req_ready && rdy_t < 0) rdy_t = t - acc;
            if (commands[7]) pr_cnt++;
        end
        n_cmp++;
        if (col_t != T_RCD || col_state !== burst_code) begin
            n_err++; $display("FAIL col_timing wr=%0d got off=%0d st=%h exp off=%0d st=%h", wr, col_t, col_state, T_RCD, burst_code);
        end
        n_cmp++;
        if (pre_t != T_RCD + d) begin
            n_err++; $display("FAIL precharge_entry wr=%0d got=%0d exp=%0d", wr, pre_t, T_RCD + d);
        end
        n_cmp++;
        if (rdy_t != T_RCD + d + T_RP) begin
            n_err++; $display("FAIL ready_return wr=%0d got=%0d exp=%0d", wr, rdy_t, T_RCD + d + T_RP);
        end
        n_cmp++;
        if (pr_cnt != (AP ? 0 : 1)) begin
            n_err++; $display("FAIL pr_pulses wr=%0d got=%0d exp=%0d", wr, pr_cnt, AP ? 0 : 1);
        end
    endtask

    task automatic test_refresh_idle();
        int pend_t = -1, ref_t = -1, rdy_t = -1;
        apply_reset();
        req_valid = 0;
        for (int i = 0; i < 140; i++) begin
            tick();
            n_cmp++;
            if (dut_bus !== expected()) begin
                n_err++; $display("FAIL refresh_idle_cycle t=%0d got=%h exp=%h", t, dut_bus, expected());
            end
            if (ref_pending && pend_t < 0) pend_t = t;
            if (commands[3] && ref_t < 0) ref_t = t;
            if (ref_t > 0 && req_ready && rdy_t < 0) rdy_t = t;
        end
        n_cmp++;
        if (pend_t != TREFI || ref_t != TREFI + 1 || rdy_t != TREFI + 1 + T_RFC) begin
            n_err++; $display("FAIL refresh_idle_timing got pend=%0d ref=%0d rdy=%0d exp pend=%0d ref=%0d rdy=%0d",
                              pend_t, ref_t, rdy_t, TREFI, TREFI + 1, TREFI + 1 + T_RFC);
        end
    endtask

    task automatic test_refresh_during_write();
        int acc, ref_t = -1, act2_t = -1;
        apply_reset();
        req_valid = 0;
        while (t < 79) tick();
        req_valid = 1; req_write = 1; req_bg = 2'd2; req_ba = 2'd3; req_row = 16'h0bee;
        tick();
        acc = t;
        req_write = 0; req_row = 16'h5a5a;
        while (t < 175) begin
            tick();
            n_cmp++;
            if (dut_bus !== expected()) begin
                n_err++; $display("FAIL refresh_mid_cycle t=%0d got=%h exp=%h", t, dut_bus, expected());
            end
            if (commands[3] && ref_t < 0) ref_t = t;
            if (commands[18] && act2_t < 0) act2_t = t;
        end
        req_valid = 0;
        n_cmp++;
        if (ref_t != acc + T_RCD + T_WR + T_RP + 1 || act2_t != ref_t + T_RFC + 1) begin
            n_err++; $display("FAIL refresh_deferred got ref=%0d act2=%0d exp ref=%0d act2=%0d",
                              ref_t, act2_t, acc + T_RCD + T_WR + T_RP + 1, acc + T_RCD + T_WR + T_RP + T_RFC + 2);
        end
    endtask

    task automatic test_reset_mid_sequence();
        apply_reset();
        tick();
        req_valid = 1; req_write = 1; req_bg = 2'd3; req_ba = 2'd2; req_row = 16'h7777;
        tick();
        req_valid = 0;
        while (t < 10) tick();
        #2 reset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_bus !== 46'h0) begin
            n_err++; $display("FAIL async_reset got=%h exp=%h", dut_bus, 46'h0);
        end
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (dut_bus !== 46'h0) begin
                n_err++; $display("FAIL held_reset i=%0d got=%h exp=%h", i, dut_bus, 46'h0);
            end
        end
        reset_n = 1'b1;
        tick();
        req_valid = 1; req_write = 0; req_bg = 2'd1; req_ba = 2'd0; req_row = 16'habcd;
        tick();
        req_valid = 0;
        n_cmp++;
        if (commands !== 19'h40000 || row !== 16'habcd || seq_state !== 5'h01) begin
            n_err++; $display("FAIL restart_act got cmd=%h row=%h st=%h exp cmd=40000 row=abcd st=01", commands, row, seq_state);
        end
        repeat (5) begin
            tick();
            n_cmp++;
            if (dut_bus !== expected()) begin
                n_err++; $display("FAIL restart_cycle t=%0d got=%h exp=%h", t, dut_bus, expected());
            end
        end
    endtask

    task automatic test_random_traffic();
        apply_reset();
        for (int i = 0; i < 4000; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_write = 1'($urandom);
            req_bg    = 2'($urandom);
            req_ba    = 2'($urandom);
            req_row   = 16'($urandom);
            if ($urandom_range(0, 1499) == 0) apply_reset();
            tick();
            n_cmp++;
            if (dut_bus !== expected()) begin
                n_err++; $display("FAIL random_cycle i=%0d t=%0d got=%h exp=%h", i, t, dut_bus, expected());
            end
        end
        req_valid = 0;
    endtask

    initial begin
        reset_n = 0; req_valid = 0; req_write = 0; req_bg = '0; req_ba = '0; req_row = '0;
        model_reset();
        test_reset();
        test_access(1'b1);
        test_access(1'b0);
        test_refresh_idle();
        test_refresh_during_write();
        test_reset_mid_sequence();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
